// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a return-address stack.
// Each cycle one next-PC source is chosen in fixed priority order:
// trap, redirect, stall, return, jump, then sequential PC+4.
// The return-address stack (RAS) is a circular buffer. Pushing when
// the stack is full overwrites the oldest entry. Popping when it is
// empty is ignored, and the PC falls through to PC+4.
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4,
    localparam int              CNT_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             a_reset_n,
    input  logic             i_stall,
    input  logic             i_trap,
    input  logic [WIDTH-1:0] i_trap_vector,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_target,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_call,
    input  logic             i_ret,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_ras_count,
    output logic             o_ras_empty,
    output logic             o_ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    // Winning next-PC source for the current cycle. A call is a jump
    // that also pushes onto the RAS, so it has its own value.
    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_JUMP,
        SEL_SEQ
    } next_sel_t;

    logic [WIDTH-1:0] r_pc;
    logic [PTR_W-1:0] r_wr_ptr;    // slot the next push writes to
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_ras_mem [RAS_DEPTH];

    logic [WIDTH-1:0] w_pc_plus4;
    logic [PTR_W-1:0] w_top_ptr;   // slot holding the most recent push
    logic [PTR_W-1:0] w_inc_ptr;
    logic             w_full;
    logic             w_empty;
    next_sel_t        w_sel;

    // Pick the winning next-PC source and compute the RAS pointer neighbours.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        w_sel      = SEL_SEQ;
        w_pc_plus4 = r_pc + WIDTH'(4);
        w_full     = (r_count == CNT_W'(RAS_DEPTH));
        w_empty    = (r_count == '0);
        w_top_ptr  = (r_wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_wr_ptr - PTR_W'(1);
        w_inc_ptr  = (r_wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

        if (i_trap) begin
            w_sel = SEL_TRAP;
        end else if (i_redirect) begin
            w_sel = SEL_REDIRECT;
        end else if (i_stall) begin
            w_sel = SEL_HOLD;
        end else if (i_ret) begin
            // The return beats a jump even when the stack is empty.
            // In that case it falls through to the sequential PC.
            w_sel = w_empty ? SEL_SEQ : SEL_RET;
        end else if (i_jump) begin
            w_sel = i_call ? SEL_CALL : SEL_JUMP;
        end
    end

    // PC register and RAS bookkeeping; reset clears count and pointer immediately.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_pc     <= RESET_VECTOR;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
            unique case (w_sel)
                SEL_TRAP: begin
                    r_pc     <= i_trap_vector;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end
                SEL_REDIRECT: r_pc <= i_redirect_target;
                SEL_HOLD:     r_pc <= r_pc;
                SEL_RET: begin
                    r_pc     <= r_ras_mem[w_top_ptr];
                    r_wr_ptr <= w_top_ptr;
                    r_count  <= r_count - CNT_W'(1);
                end
                SEL_CALL: begin
                    r_pc     <= i_jump_target;
                    r_wr_ptr <= w_inc_ptr;
                    if (!w_full) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                SEL_JUMP: r_pc <= i_jump_target;
                default:  r_pc <= w_pc_plus4;
            endcase
        end
    end

    // Return-address storage; a call writes PC+4 into the next slot.
    always_ff @(posedge clk) begin
        // NOTE: the entries have no reset, because count and pointer alone decide which entries are valid.
        if (w_sel == SEL_CALL) begin
            r_ras_mem[r_wr_ptr] <= w_pc_plus4;
        end
    end

    assign o_pc         = r_pc;
    assign o_misaligned = |r_pc[1:0];
    assign o_ras_count  = r_count;
    assign o_ras_empty  = w_empty;
    assign o_ras_full   = w_full;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen.
// A behavioural model tracks the expected PC and keeps the return stack as a queue.
module tb_pc_gen;

    localparam int          WIDTH     = 32;
    localparam int          RAS_DEPTH = 4;
    localparam int          CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam logic [31:0] RV        = 32'h0;

    logic             clk;
    logic             a_reset_n;
    logic             i_stall;
    logic             i_trap;
    logic [WIDTH-1:0] i_trap_vector;
    logic             i_redirect;
    logic [WIDTH-1:0] i_redirect_target;
    logic             i_jump;
    logic [WIDTH-1:0] i_jump_target;
    logic             i_call;
    logic             i_ret;
    logic [WIDTH-1:0] o_pc;
    logic             o_misaligned;
    logic [CNT_W-1:0] o_ras_count;
    logic             o_ras_empty;
    logic             o_ras_full;

    pc_gen #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (RAS_DEPTH)
    ) dut (
        .clk               (clk),
        .a_reset_n         (a_reset_n),
        .i_stall           (i_stall),
        .i_trap            (i_trap),
        .i_trap_vector     (i_trap_vector),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .i_jump            (i_jump),
        .i_jump_target     (i_jump_target),
        .i_call            (i_call),
        .i_ret             (i_ret),
        .o_pc              (o_pc),
        .o_misaligned      (o_misaligned),
        .o_ras_count       (o_ras_count),
        .o_ras_empty       (o_ras_empty),
        .o_ras_full        (o_ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_ras[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_stall           = 1'b0;
        i_trap            = 1'b0;
        i_trap_vector     = '0;
        i_redirect        = 1'b0;
        i_redirect_target = '0;
        i_jump            = 1'b0;
        i_jump_target     = '0;
        i_call            = 1'b0;
        i_ret             = 1'b0;
    endtask

    // Apply the architectural rules to the model for one clock edge.
    function automatic void model_step();
        if (i_trap) begin
            m_pc = i_trap_vector;
            m_ras.delete();
        end else if (i_redirect) begin
            m_pc = i_redirect_target;
        end else if (i_stall) begin
            m_pc = m_pc;
        end else if (i_ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else                  m_pc = m_pc + 32'd4;
        end else if (i_jump) begin
            if (i_call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
            m_pc = i_jump_target;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    task automatic compare_all();
        check("pc",         64'(o_pc),         64'(m_pc));
        check("ras_count",  64'(o_ras_count),  64'(m_ras.size()));
        check("ras_empty",  64'(o_ras_empty),  64'(m_ras.size() == 0));
        check("ras_full",   64'(o_ras_full),   64'(m_ras.size() == RAS_DEPTH));
        check("misaligned", 64'(o_misaligned), 64'(m_pc[1:0] != 2'b00));
    endtask

    // One clock edge: the model consumes the stable inputs, then the outputs are compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        idle_inputs();
    endtask

    task automatic reset_model();
        m_pc = RV;
        m_ras.delete();
    endtask

    task automatic do_jump(input logic [31:0] tgt, input logic call);
        i_jump        = 1'b1;
        i_jump_target = tgt;
        i_call        = call;
        tick();
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        i_redirect        = 1'b1;
        i_redirect_target = tgt;
        tick();
    endtask

    task automatic do_ret();
        i_ret = 1'b1;
        tick();
    endtask

    initial begin
        idle_inputs();
        a_reset_n = 1'b0;
        reset_model();
        #2;
        check("reset_pc",    64'(o_pc),        64'(RV));
        check("reset_count", 64'(o_ras_count), 64'd0);
        check("reset_empty", 64'(o_ras_empty), 64'd1);
        check("reset_full",  64'(o_ras_full),  64'd0);
        @(negedge clk);
        a_reset_n = 1'b1;

        // Three idle cycles after reset release.
        tick(); check("idle_pc4",  64'(o_pc), 64'h4);
        tick(); check("idle_pc8",  64'(o_pc), 64'h8);
        tick(); check("idle_pc12", 64'(o_pc), 64'hC);

        // Call, then return.
        do_redirect(32'h100);
        do_jump(32'h400, 1'b1);
        check("call_pc",    64'(o_pc),        64'h400);
        check("call_count", 64'(o_ras_count), 64'd1);
        do_ret();
        check("ret_pc",    64'(o_pc),        64'h104);
        check("ret_count", 64'(o_ras_count), 64'd0);

        // Five calls into a four-entry stack, then five returns.
        do_redirect(32'h1000);
        for (int k = 0; k < 5; k++) begin
            do_jump(32'h2000 + 32'(k) * 32'h10, 1'b1);
            if (k == 3) check("full_after_4", 64'(o_ras_full), 64'd1);
        end
        check("count_after_5", 64'(o_ras_count), 64'(RAS_DEPTH));
        do_ret(); check("ret1", 64'(o_pc), 64'h2034);
        do_ret(); check("ret2", 64'(o_pc), 64'h2024);
        do_ret(); check("ret3", 64'(o_pc), 64'h2014);
        do_ret(); check("ret4", 64'(o_pc), 64'h2004);
        do_ret(); check("ret5_fall", 64'(o_pc), 64'h2008);

        // A stall overrides jump and return together; a redirect overrides a stall.
        do_jump(32'h3000, 1'b1);
        i_stall = 1'b1; i_jump = 1'b1; i_jump_target = 32'h5000; i_ret = 1'b1; i_call = 1'b1;
        tick();
        check("stall_pc",    64'(o_pc),        64'h3000);
        check("stall_count", 64'(o_ras_count), 64'd1);
        i_stall = 1'b1; i_redirect = 1'b1; i_redirect_target = 32'h200;
        tick();
        check("stall_redir", 64'(o_pc), 64'h200);

        // A trap beats a redirect and clears the stack; then a misaligned redirect.
        do_jump(32'h600, 1'b1);
        do_jump(32'h700, 1'b1);
        check("count3", 64'(o_ras_count), 64'd3);
        i_trap = 1'b1; i_trap_vector = 32'h80; i_redirect = 1'b1; i_redirect_target = 32'h900;
        tick();
        check("trap_pc",    64'(o_pc),        64'h80);
        check("trap_count", 64'(o_ras_count), 64'd0);
        do_redirect(32'h202);
        check("misaligned", 64'(o_misaligned), 64'd1);

        // PC+4 wraps to zero at the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        tick();
        check("wrap_pc", 64'(o_pc), 64'h0);

        // Asynchronous reset asserted between edges while a call is pending.
        do_jump(32'h800, 1'b1);
        i_jump = 1'b1; i_jump_target = 32'h900; i_call = 1'b1;
        #2;
        a_reset_n = 1'b0;
        #1;
        check("async_rst_pc",    64'(o_pc),        64'(RV));
        check("async_rst_count", 64'(o_ras_count), 64'd0);
        check("async_rst_empty", 64'(o_ras_empty), 64'd1);
        @(posedge clk);
        #1;
        check("rst_held_pc", 64'(o_pc), 64'(RV));
        @(negedge clk);
        idle_inputs();
        a_reset_n = 1'b1;
        reset_model();
        tick();
        check("post_rst_pc", 64'(o_pc), 64'(RV) + 64'd4);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            i_trap            = ($urandom_range(0, 29) == 0);
            i_trap_vector     = $urandom & 32'hFFFF_FFFC;
            i_redirect        = ($urandom_range(0, 11) == 0);
            i_redirect_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            i_stall           = ($urandom_range(0, 5) == 0);
            i_ret             = ($urandom_range(0, 3) == 0);
            i_jump            = ($urandom_range(0, 2) == 0);
            i_jump_target     = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            i_call            = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
